// File: rtl/pattern_serializer_pkg.sv
// statespace_pkg
// Shared definitions for the pattern serializer and the downstream
// two-zeros/two-ones detector bench: serializer state encoding, the
// default pattern width and the canonical 12-bit example vector.
package statespace_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } ser_state_t;

  localparam int SER_W = 12;

  // Sequence 0 1 1 1 0 1 0 1 0 1 1 0 when sent MSB-first.
  localparam logic [11:0] SER_EXAMPLE_VEC = 12'h756;

endpackage

// File: rtl/pattern_serializer_rate_tick.sv
// rate_tick
// Modulo-DIV hold counter for the serializer. Counts 0..DIV-1 while
// enabled and returns to 0 on a synchronous clear.
// Ports:
//   Clock, Resetn : clock and async active-low reset
//   i_clear       : synchronous clear, wins over i_enable
//   i_enable      : advance the count this cycle
//   o_first       : count is 0 (first clock of a bit)
//   o_last        : count is DIV-1 (last clock of a bit)
// With DIV=1 the count never leaves 0, so both strobes stay high.
module rate_tick #(
  parameter int DIV = 1
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_first,
  output logic o_last
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last  = (r_cnt == CW'(DIV - 1));
  assign o_first = (r_cnt == '0);
  assign o_last  = w_last;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer
// Captures a parallel pattern on Start and shifts it out MSB-first,
// one bit every DIV clocks, for the sequence detector.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | outputs low, waiting for Start (blocked by Abort)
// SHIFT | emitting bits, Busy high, BitValid on each bit's first clock
// DONE  | one-cycle Done pulse, Start ignored, then back to IDLE
//
// Ports:
//   Clock, Resetn      : clock and async active-low reset
//   Start, Abort       : launch request (IDLE only) / synchronous cancel
//   Pattern, Length    : pattern bits and bit count, captured on launch
//   Bit, BitValid      : serial data and new-bit strobe
//   Busy, Done         : streaming flag and end-of-stream pulse
module pattern_serializer
  import statespace_pkg::*;
#(
  parameter int W   = SER_W,
  parameter int DIV = 1,
  parameter int LW  = $clog2(W + 1)
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Abort,
  input  logic [W-1:0]  Pattern,
  input  logic [LW-1:0] Length,
  output logic          Bit,
  output logic          BitValid,
  output logic          Busy,
  output logic          Done
);

  ser_state_t    r_state;
  logic [W-1:0]  r_shift;
  logic [LW-1:0] r_remain;
  logic          r_bit;
  logic          r_bit_valid;
  logic          r_busy;
  logic          r_done;

  logic [LW-1:0] w_len;
  logic [W-1:0]  w_aligned;
  logic [W-1:0]  w_shift_next;
  logic          w_first;
  logic          w_last;

  // Left-justify the pattern so the first bit to send, Pattern[len-1],
  // always sits at the register MSB; higher pattern bits fall off.
  always_comb begin
    w_len        = (Length > LW'(W)) ? LW'(W) : Length;
    w_aligned    = Pattern << (W - int'(w_len));
    w_shift_next = r_shift << 1;
  end

  rate_tick #(
    .DIV(DIV)
  ) u_rate_tick (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .i_clear  ((r_state != S_SHIFT) || Abort),
    .i_enable (r_state == S_SHIFT),
    .o_first  (w_first),
    .o_last   (w_last)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_remain    <= '0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (Abort) begin
      r_state     <= S_IDLE;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit       <= 1'b0;
          r_bit_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          if (Start) begin
            r_shift  <= w_aligned;
            r_remain <= w_len;
            if (w_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_SHIFT;
              r_bit       <= w_aligned[W-1];
              r_bit_valid <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (w_last) begin
            if (r_remain == LW'(1)) begin
              r_state     <= S_DONE;
              r_remain    <= '0;
              r_bit       <= 1'b0;
              r_bit_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_shift     <= w_shift_next;
              r_remain    <= r_remain - LW'(1);
              r_bit       <= w_shift_next[W-1];
              r_bit_valid <= 1'b1;
            end
          end else if (w_first) begin
            // Only the first hold clock of a bit carries the strobe.
            r_bit_valid <= 1'b0;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_bit       <= 1'b0;
          r_bit_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign Bit      = r_bit;
  assign BitValid = r_bit_valid;
  assign Busy     = r_busy;
  assign Done     = r_done;

endmodule

// File: tb/tb_pattern_serializer.sv
module tb_pattern_serializer;

  logic        clk;
  logic        rstn;
  logic        start1;
  logic        start3;
  logic        abort;
  logic [11:0] pattern;
  logic [3:0]  length;
  logic        bit1, valid1, busy1, done1;
  logic        bit3, valid3, busy3, done3;

  int total = 0;
  int bad   = 0;

  // Expected per-cycle output tuples {Done, Busy, BitValid, Bit}, index 0
  // being the cycle right after the accepted Start edge.
  logic [3:0] exp_q[$];

  pattern_serializer #(.W(12), .DIV(1)) dut1 (
    .Clock(clk), .Resetn(rstn), .Start(start1), .Abort(abort),
    .Pattern(pattern), .Length(length),
    .Bit(bit1), .BitValid(valid1), .Busy(busy1), .Done(done1)
  );

  pattern_serializer #(.W(12), .DIV(3)) dut3 (
    .Clock(clk), .Resetn(rstn), .Start(start3), .Abort(abort),
    .Pattern(pattern), .Length(length),
    .Bit(bit3), .BitValid(valid3), .Busy(busy3), .Done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each of the min(len,12) bits, highest first, held div
  // clocks with the strobe on the first one, followed by one Done cycle.
  function automatic void build(input logic [11:0] pat, input int len, input int div);
    int n;
    n = (len > 12) ? 12 : len;
    for (int i = n - 1; i >= 0; i--)
      for (int h = 0; h < div; h++)
        exp_q.push_back({1'b0, 1'b1, (h == 0), pat[i]});
    exp_q.push_back(4'b1000);
  endfunction

  task automatic sample(input int sel, output logic [3:0] obs);
    @(negedge clk);
    obs = (sel == 1) ? {done1, busy1, valid1, bit1} : {done3, busy3, valid3, bit3};
  endtask

  task automatic launch(input int sel, input logic [11:0] pat, input logic [3:0] len);
    @(negedge clk);
    pattern = pat;
    length  = len;
    if (sel == 1) start1 = 1'b1;
    else          start3 = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] o;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    for (int s = 1; s <= 3; s += 2) begin
      sample(s, o);
      total++;
      if (o !== 4'b0000) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%b exp=0000", s, o);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample(1, o);
      total++;
      if (o !== 4'b0000) begin
        bad++;
        $display("FAIL reset_release c=%0d got=%b exp=0000", c, o);
      end
    end
  endtask

  task automatic run_stream(input string name, input int sel, input logic [11:0] pat,
                            input logic [3:0] len);
    logic [3:0] o, e;
    int n;
    exp_q.delete();
    build(pat, int'(len), (sel == 1) ? 1 : 3);
    n = exp_q.size() + 2;
    launch(sel, pat, len);
    for (int c = 0; c < n; c++) begin
      sample(sel, o);
      if (c == 0) begin start1 = 1'b0; start3 = 1'b0; end
      e = (c < exp_q.size()) ? exp_q[c] : 4'b0000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s dut%0d pat=%h len=%0d c=%0d got=%b exp=%b", name, sel, pat, len, c, o, e);
      end
    end
  endtask

  task automatic test_basic();
    run_stream("basic", 1, 12'h756, 4'd12);
  endtask

  task automatic test_rate_divider();
    run_stream("rate_div", 3, 12'h009, 4'd4);
  endtask

  task automatic test_length_edges();
    run_stream("len0", 1, 12'hABC, 4'd0);
    run_stream("len0_div", 3, 12'hABC, 4'd0);
    run_stream("len15", 1, 12'hA5C, 4'd15);
    run_stream("len3", 1, 12'hFF5, 4'd3);
    run_stream("len1_div", 3, 12'h001, 4'd1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_stream("random", (i % 2 == 0) ? 1 : 3, 12'($urandom),
                 4'($urandom_range(0, 15)));
  endtask

  // Start re-raised mid-stream with a new pattern and held through DONE.
  task automatic test_back_to_back();
    logic [3:0] o, e;
    int n, drop;
    exp_q.delete();
    build(12'h756, 12, 1);
    exp_q.push_back(4'b0000);
    drop = exp_q.size();
    build(12'h0F3, 8, 1);
    n = exp_q.size() + 3;
    launch(1, 12'h756, 4'd12);
    for (int c = 0; c < n; c++) begin
      sample(1, o);
      if (c == 0) start1 = 1'b0;
      if (c == 3) begin
        pattern = 12'h0F3;
        length  = 4'd8;
        start1  = 1'b1;
      end
      if (c == drop) start1 = 1'b0;
      e = (c < exp_q.size()) ? exp_q[c] : 4'b0000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, o, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] o, e;
    exp_q.delete();
    build(12'h756, 12, 1);
    launch(1, 12'h756, 4'd12);
    for (int c = 0; c < 16; c++) begin
      sample(1, o);
      if (c == 0) start1 = 1'b0;
      if (c == 4) abort = 1'b1;
      if (c == 5) abort = 1'b0;
      e = (c < 5) ? exp_q[c] : 4'b0000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort_mid c=%0d got=%b exp=%b", c, o, e);
      end
    end
    // Abort in IDLE blocks a simultaneous Start.
    @(negedge clk);
    pattern = 12'h800;
    length  = 4'd12;
    abort   = 1'b1;
    start1  = 1'b1;
    sample(1, o);
    abort = 1'b0;
    total++;
    if (o !== 4'b0000) begin
      bad++;
      $display("FAIL abort_idle got=%b exp=0000", o);
    end
    exp_q.delete();
    build(12'h800, 12, 1);
    for (int c = 0; c < exp_q.size() + 2; c++) begin
      sample(1, o);
      if (c == 0) start1 = 1'b0;
      e = (c < exp_q.size()) ? exp_q[c] : 4'b0000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort_relaunch c=%0d got=%b exp=%b", c, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] o, e;
    exp_q.delete();
    build(12'hFFF, 12, 1);
    launch(1, 12'hFFF, 4'd12);
    for (int c = 0; c < 4; c++) begin
      sample(1, o);
      if (c == 0) start1 = 1'b0;
      e = exp_q[c];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid_pre c=%0d got=%b exp=%b", c, o, e);
      end
    end
    #1 rstn = 1'b0;
    #1;
    o = {done1, busy1, valid1, bit1};
    total++;
    if (o !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async got=%b exp=0000", o);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample(1, o);
      total++;
      if (o !== 4'b0000) begin
        bad++;
        $display("FAIL reset_mid_idle c=%0d got=%b exp=0000", c, o);
      end
    end
  endtask

  initial begin
    rstn    = 1'b0;
    start1  = 1'b0;
    start3  = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    length  = '0;
    test_reset();
    test_basic();
    test_rate_divider();
    test_length_edges();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
